// File: rtl/i2c_write_master.sv
// i2c_write_master: write-only I2C master that sends a 3-byte frame and reports ACK/NACK
module i2c_write_master #(
  parameter int CLK_DIV = 62
) (
  input  logic        clock_25,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  slave_address,
  input  logic [15:0] register_data,
  input  logic        i2c_serial_data_input,
  output logic        i2c_serial_data_output,
  output logic        i2c_serial_clock,
  output logic        stop,
  output logic        ack
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACKBIT, S_STOP, S_FREE} state_e;
  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  qtr_q, qtr_d;
  logic [2:0]  bit_q, bit_d;
  logic [1:0]  byte_q, byte_d;
  logic [23:0] shift_q, shift_d;
  logic [1:0]  sync_q;
  logic        stop_q, stop_d, ack_q, ack_d, scl_q, scl_d, sda_q, sda_d;
  logic        tick;
  assign tick = cnt_q == CW'(CLK_DIV - 1);
  assign i2c_serial_clock = scl_q;
  assign i2c_serial_data_output = sda_q;
  assign stop = stop_q;
  assign ack = ack_q;
  // Sequencing: acceptance in IDLE, otherwise one step per quarter tick
  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    ack_d   = ack_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        shift_d = {slave_address, register_data};
        stop_d  = 1'b1;
        ack_d   = 1'b0;
        state_d = S_START;
        qtr_d   = 2'd0;
        cnt_d   = '0;
      end
    end else if (tick) begin
      qtr_d = qtr_q + 2'd1;
      case (state_q)
        S_START: if (qtr_q == 2'd1) begin
          state_d = S_BIT;
          qtr_d   = 2'd0;
          bit_d   = 3'd7;
          byte_d  = 2'd0;
        end
        S_BIT: if (qtr_q == 2'd3) begin
          shift_d = {shift_q[22:0], 1'b0};
          if (bit_q == 3'd0) state_d = S_ACKBIT;
          else bit_d = bit_q - 3'd1;
        end
        S_ACKBIT: begin
          if (qtr_q == 2'd2) ack_d = sync_q[1];
          if (qtr_q == 2'd3) begin
            if (ack_q || byte_q == 2'd2) state_d = S_STOP;
            else begin
              byte_d  = byte_q + 2'd1;
              bit_d   = 3'd7;
              state_d = S_BIT;
            end
          end
        end
        S_STOP: if (qtr_q == 2'd2) begin
          state_d = S_FREE;
          qtr_d   = 2'd0;
        end
        S_FREE: if (qtr_q == 2'd1) begin
          state_d = S_IDLE;
          qtr_d   = 2'd0;
          stop_d  = 1'b0;
        end
        default: ;
      endcase
    end
  end
  // Pin levels decoded from the next state so the registered pins line up with the state
  always_comb begin
    scl_d = 1'b1;
    sda_d = 1'b1;
    case (state_d)
      S_START: begin
        scl_d = qtr_d == 2'd0;
        sda_d = 1'b0;
      end
      S_BIT: begin
        scl_d = qtr_d[1];
        sda_d = shift_d[23];
      end
      S_ACKBIT: scl_d = qtr_d[1];
      S_STOP: begin
        scl_d = qtr_d != 2'd0;
        sda_d = qtr_d == 2'd2;
      end
      default: ;
    endcase
  end
  // State, counters, synchronizer and glitch-free registered pins
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      byte_q  <= 2'd0;
      shift_q <= 24'd0;
      sync_q  <= 2'b11;
      stop_q  <= 1'b0;
      ack_q   <= 1'b0;
      scl_q   <= 1'b1;
      sda_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shift_q <= shift_d;
      sync_q  <= {sync_q[0], i2c_serial_data_input};
      stop_q  <= stop_d;
      ack_q   <= ack_d;
      scl_q   <= scl_d;
      sda_q   <= sda_d;
    end
  end
endmodule

// File: tb/tb_i2c_write_master.sv
// tb_i2c_write_master: table, random and corner-case checks of the I2C write master
module tb_i2c_write_master;
  localparam int DIV = 4;
  logic clk = 0;
  logic rst_n = 1;
  logic start = 0;
  logic [7:0] sa = 0;
  logic [15:0] rd = 0;
  logic sda_o, scl, stop, ack;
  logic pull = 0;
  logic sda_in;
  assign sda_in = sda_o & ~pull;
  always #5 clk = ~clk;
  i2c_write_master #(.CLK_DIV(DIV)) dut (
    .clock_25(clk),
    .reset(rst_n),
    .start(start),
    .slave_address(sa),
    .register_data(rd),
    .i2c_serial_data_input(sda_in),
    .i2c_serial_data_output(sda_o),
    .i2c_serial_clock(scl),
    .stop(stop),
    .ack(ack)
  );
  int vectors = 0, miscompares = 0;
  int nack_at = 3, pulses = 0, bitn = 0;
  logic in_bit = 0, pscl = 1, psda = 1;
  logic [7:0] cur = 0;
  logic [7:0] rx[$];
  // Slave model: collects bytes, counts complete SCL pulses, ACKs every byte except nack_at
  always @(negedge clk) begin
    if (pscl && scl && psda && !sda_in) begin
      pulses = 0;
      bitn = 0;
      in_bit = 0;
      pull = 0;
      rx.delete();
    end else if (!pscl && scl) begin
      in_bit = 1;
      if (bitn < 8) cur = {cur[6:0], sda_in};
      bitn++;
      if (bitn == 8) rx.push_back(cur);
    end else if (pscl && !scl) begin
      if (in_bit) pulses++;
      in_bit = 0;
      if (bitn == 8) pull = (int'(rx.size()) - 1 != nack_at);
      else if (bitn >= 9) begin
        pull = 0;
        bitn = 0;
      end
    end
    pscl = scl;
    psda = sda_in;
  end
  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask
  function automatic int model_bytes(input int nk);
    return nk < 3 ? nk + 1 : 3;
  endfunction
  task automatic do_txn(input string nm, input logic [7:0] a, input logic [15:0] d, input int nk,
                        input int exp_len, input int exp_ack, input int exp_pulses,
                        input bit hold, input bit disturb, input logic [15:0] nd);
    int gap, len, k, got;
    logic [23:0] full;
    nack_at = nk;
    sa = a;
    rd = d;
    start = 1;
    gap = 0;
    while (!stop && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    chk({nm, " accept latency"}, gap, 1);
    chk({nm, " ack cleared"}, int'(ack), 0);
    len = 0;
    while (stop && len < 2000) begin
      len++;
      start = hold || (disturb && len >= 100 && len < 200);
      if (disturb && len == 100) rd = 16'h9803;
      if (hold && len == exp_len - 4) rd = nd;
      @(negedge clk);
    end
    chk({nm, " stop length"}, len, exp_len);
    chk({nm, " ack"}, int'(ack), exp_ack);
    chk({nm, " scl pulses"}, pulses, exp_pulses);
    k = exp_pulses / 9;
    full = {a, d};
    got = 0;
    foreach (rx[i]) got = (got << 8) | int'(rx[i]);
    chk({nm, " byte count"}, rx.size(), k);
    chk({nm, " bytes"}, got, int'(full >> (8 * (3 - k))));
  endtask
  typedef struct {
    logic [7:0]  a;
    logic [15:0] d;
    int nk;
    int len;
    int ackv;
    int pulses;
  } vec_t;
  vec_t tbl[6];
  initial begin
    tbl[0] = '{8'h72, 16'h4110, 3, 460, 0, 27};
    tbl[1] = '{8'h72, 16'h4110, 0, 172, 1, 9};
    tbl[2] = '{8'h72, 16'h4110, 2, 460, 1, 27};
    tbl[3] = '{8'h72, 16'h4110, 1, 316, 1, 18};
    tbl[4] = '{8'hff, 16'h0000, 3, 460, 0, 27};
    tbl[5] = '{8'h00, 16'hffff, 3, 460, 0, 27};
    #2 rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset scl", int'(scl), 1);
    chk("reset sda", int'(sda_o), 1);
    chk("reset stop", int'(stop), 0);
    chk("reset ack", int'(ack), 0);
    rst_n = 1;
    foreach (tbl[i]) begin
      do_txn($sformatf("vec%0d", i), tbl[i].a, tbl[i].d, tbl[i].nk, tbl[i].len, tbl[i].ackv, tbl[i].pulses, 0, 0, 0);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d ack hold", i), int'(ack), tbl[i].ackv);
      chk($sformatf("vec%0d idle scl", i), int'(scl), 1);
      chk($sformatf("vec%0d idle sda", i), int'(sda_o), 1);
    end
    do_txn("disturb", 8'h72, 16'h4110, 3, 460, 0, 27, 0, 1, 0);
    do_txn("b2b first", 8'h72, 16'h4110, 3, 460, 0, 27, 1, 0, 16'hbeef);
    do_txn("b2b second", 8'h72, 16'hbeef, 3, 460, 0, 27, 0, 0, 0);
    nack_at = 3;
    sa = 8'h72;
    rd = 16'h4110;
    start = 1;
    for (int i = 0; i < 20 && !stop; i++) @(negedge clk);
    start = 0;
    repeat (219) @(negedge clk);
    chk("pre-reset stop", int'(stop), 1);
    chk("pre-reset sda driven", int'(sda_o), 0);
    rst_n = 0;
    #1;
    chk("midreset scl", int'(scl), 1);
    chk("midreset sda", int'(sda_o), 1);
    chk("midreset stop", int'(stop), 0);
    chk("midreset ack", int'(ack), 0);
    @(negedge clk);
    rst_n = 1;
    do_txn("after reset", 8'h72, 16'h4110, 3, 460, 0, 27, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a;
      logic [15:0] d;
      int nk, k;
      a = 8'($urandom);
      d = 16'($urandom);
      nk = int'($urandom_range(0, 3));
      k = model_bytes(nk);
      do_txn($sformatf("rand%0d", i), a, d, nk, (7 + 36 * k) * DIV, nk < 3 ? 1 : 0, 9 * k, 0, 0, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/i2c_write_master.md
I2C_WRITE_MASTER -- requirements
Module: i2c_write_master

Interface
REQ-001 SHALL have parameter: CLK_DIV, default 62, clock_25 cycles per SCL quarter-period (SCL ≈ 100.8 kHz).
REQ-002 SHALL have ports:
- clock_25  input  1  system clock; all state on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level request; sampled only in IDLE.
- slave_address  input  8  first byte sent, R/W bit included (e.g. 8'h72).
- register_data  input  16  [15:8] second byte, [7:0] third byte.
- i2c_serial_data_input  input  1  raw SDA pin level.
- i2c_serial_data_output  output  1  1 = release SDA (parent tristates), 0 = drive low.
- i2c_serial_clock  output  1  SCL level.
- stop  output  1  1 while a transaction is in progress, 0 when idle.
- ack  output  1  result of last transaction: 0 = all bytes ACKed, 1 = NACK seen.

Function
REQ-003 SHALL derive a quarter tick from a counter over 0..CLK_DIV-1; the tick fires at count CLK_DIV-1; the counter is cleared on transaction acceptance.
REQ-004 SHALL pass i2c_serial_data_input through a 2-flop synchronizer before any sampling.
REQ-005 SHALL implement states IDLE, START, BIT, ACKBIT, STOP, FREE; each state is advanced only on quarter ticks.
REQ-006 SHALL accept a transaction in IDLE when start = 1:
- latch {slave_address, register_data} into a 24-bit shift register;
- set stop = 1 on the next cycle;
- enter START.
REQ-007 START, 2 quarters:
- q0: SCL = 1, SDA = 0.
- q1: SCL = 0, SDA = 0.
- then BIT with bit counter 7, byte counter 0.
REQ-008 BIT, 4 quarters per bit, MSB first:
- q0: SCL = 0, SDA = shift[23] (1 → released).
- q1: SCL = 0.
- q2/q3: SCL = 1.
- shift left at end of q3; after bit 0, go to ACKBIT.
REQ-009 ACKBIT, 4 quarters, same SCL pattern as BIT:
- SDA released for all 4 quarters;
- synchronized SDA sampled at end of q2: 0 = ACK, 1 = NACK.
REQ-010 After ACKBIT:
- ACK with byte counter < 2: increment byte counter, return to BIT.
- ACK on byte 2: go to STOP.
- NACK: set the ack register to 1, go directly to STOP.
REQ-011 STOP, 3 quarters:
- q0: SCL = 0, SDA = 0.
- q1: SCL = 1, SDA = 0.
- q2: SCL = 1, SDA released.
REQ-012 FREE SHALL hold SCL = 1 and SDA released for 2 quarters, then drive stop = 0 and enter IDLE.
REQ-013 ack SHALL be cleared to 0 on acceptance and hold its final value from end of transaction until the next acceptance.
REQ-014 start, slave_address and register_data SHALL be ignored while stop = 1; latched data SHALL be immune to input changes mid-transaction.
REQ-015 If start is still 1 on the first IDLE cycle, a new transaction SHALL be accepted immediately, with no idle gap beyond FREE.
REQ-016 A full ACKed transaction SHALL keep stop = 1 for exactly 115*CLK_DIV cycles (2 + 27×4 + 3 + 2 quarters).
REQ-017 A transaction NACKed on byte n (0..2) SHALL keep stop = 1 for (2 + (n+1)×36 + 5)*CLK_DIV cycles.
REQ-018 In IDLE, SCL SHALL be 1 and SDA released.

Reset
REQ-019 reset = 0 SHALL asynchronously force:
- state IDLE, all counters 0, shift register 0;
- i2c_serial_clock = 1, i2c_serial_data_output = 1;
- stop = 0, ack = 0.
REQ-020 Reset mid-transaction SHALL abandon the transaction with no STOP condition generated.
REQ-021 The first acceptance after reset release SHALL occur on the first clock edge with reset = 1 and start = 1.

Verification
REQ-022 CLK_DIV = 4; slave_address 8'h72, register_data 16'h4110, slave ACKs all 3 bytes.
- SDA bit stream 72,41,10 MSB first, 27 SCL rising edges;
- stop high for 460 cycles; ack = 0.
REQ-023 Slave NACKs the address byte.
- STOP immediately after the first ACKBIT, 9 SCL pulses;
- stop high for (2+36+5)×4 = 172 cycles; ack = 1.
REQ-024 Slave NACKs byte 2 (8'h10).
- 27 SCL pulses, then STOP; ack = 1.
REQ-025 start pulsed again and register_data changed to 16'h9803 mid-transaction.
- no effect; bytes on the wire remain 72,41,10.
REQ-026 start held high across two transactions, register_data updated during FREE.
- second transaction begins the cycle after stop falls and sends the new data.
REQ-027 reset asserted during byte 1, bit 3.
- same cycle: SCL = 1, SDA released, stop = 0, ack = 0;
- next start sends a clean START and the full 3 bytes.
